// File: rtl/bp_cce_ucode_ram_arbiter.sv
// Shares the single-port CCE microcode RAM between the config bus and the fetch stage,
// and sequences CFG/RUN/DRAIN ownership. Define BP_CCE_UCODE_ARB_FAIR_EN for config-read anti-starvation.
module bp_cce_ucode_ram_arbiter #(
  parameter int unsigned cce_pc_width_p    = 8,
  parameter int unsigned cce_instr_width_p = 48,
  parameter int unsigned starve_limit_p    = 8
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic                         mode_i,

  input  logic                         cfg_v_i,
  input  logic                         cfg_w_i,
  input  logic [cce_pc_width_p-1:0]    cfg_addr_i,
  input  logic [cce_instr_width_p-1:0] cfg_data_i,
  output logic                         cfg_ready_o,
  output logic                         cfg_data_v_o,
  output logic [cce_instr_width_p-1:0] cfg_data_o,

  input  logic                         fetch_v_i,
  input  logic [cce_pc_width_p-1:0]    fetch_pc_i,
  output logic                         fetch_ready_o,
  output logic                         fetch_inst_v_o,
  output logic [cce_instr_width_p-1:0] fetch_inst_o,
  input  logic                         fetch_yumi_i,

  output logic                         ram_v_o,
  output logic                         ram_w_o,
  output logic [cce_pc_width_p-1:0]    ram_addr_o,
  output logic [cce_instr_width_p-1:0] ram_data_o,
  input  logic [cce_instr_width_p-1:0] ram_data_i,

  output logic                         cce_run_o
);

  localparam logic [1:0] StReset = 2'd0;
  localparam logic [1:0] StCfg   = 2'd1;
  localparam logic [1:0] StRun   = 2'd2;
  localparam logic [1:0] StDrain = 2'd3;

  if (starve_limit_p == 0) begin : g_bad_starve_limit
    $error("starve_limit_p must be at least 1");
  end

  logic [1:0]                   state_q, state_d;
  logic                         rd_pend_q, rd_pend_d;
  logic                         owner_q, owner_d;      // 1 = fetch, 0 = config
  logic                         hold_full_q, hold_full_d;
  logic [cce_instr_width_p-1:0] hold_q, hold_d;

  logic fetch_ret, cfg_ret;
  logic cfg_rd_req, fetch_slot_free;
  logic fetch_ready, cfg_ready;
  logic fetch_grant, cfg_grant;
  logic fair_force;

  assign fetch_ret       = rd_pend_q & owner_q;
  assign cfg_ret         = rd_pend_q & ~owner_q;
  assign cfg_rd_req      = cfg_v_i & ~cfg_w_i;
  assign fetch_slot_free = ~hold_full_q | fetch_yumi_i;

`ifdef BP_CCE_UCODE_ARB_FAIR_EN
  localparam int unsigned StarveW = $clog2(starve_limit_p + 1);

  logic [StarveW-1:0] starve_q, starve_d;
  logic               in_run, starved;

  assign in_run     = (state_q == StRun);
  assign starved    = (starve_q == StarveW'(starve_limit_p));
  assign fair_force = in_run & starved & cfg_rd_req;

  always_comb begin
    starve_d = starve_q;
    if (!in_run || cfg_grant) begin
      starve_d = '0;
    end else if (cfg_rd_req && !starved) begin
      starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  assign fair_force = 1'b0;
`endif

  // Config reads in RUN only use cycles fetch leaves idle; config writes wait for CFG.
  always_comb begin
    fetch_ready = 1'b0;
    cfg_ready   = 1'b0;
    unique case (state_q)
      StCfg: cfg_ready = ~fetch_ret;
      StRun: begin
        fetch_ready = fetch_slot_free & ~fair_force;
        cfg_ready   = ~cfg_w_i & (~fetch_v_i | ~fetch_ready);
      end
      default: ;
    endcase
  end

  assign fetch_grant = fetch_v_i & fetch_ready;
  assign cfg_grant   = cfg_v_i & cfg_ready;

  assign ram_v_o    = fetch_grant | cfg_grant;
  assign ram_w_o    = cfg_grant & cfg_w_i;
  assign ram_addr_o = fetch_grant ? fetch_pc_i : (cfg_grant ? cfg_addr_i : '0);
  assign ram_data_o = ram_w_o ? cfg_data_i : '0;

  assign rd_pend_d = ram_v_o & ~ram_w_o;
  assign owner_d   = fetch_grant;

  // The hold slot is reserved at accept; data bypasses from the RAM on its return cycle
  // and is captured for later cycles, so a yumi every cycle sustains one fetch per cycle.
  always_comb begin
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    if (fetch_ret) begin
      hold_d = ram_data_i;
    end
    if (fetch_grant) begin
      hold_full_d = 1'b1;
    end else if (hold_full_q && fetch_yumi_i) begin
      hold_full_d = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StReset: state_d = StCfg;
      StCfg:   if (mode_i && !cfg_ret) state_d = StRun;
      StRun:   if (!mode_i) state_d = StDrain;
      StDrain: if (!rd_pend_q && fetch_slot_free) state_d = StCfg;
      default: state_d = StReset;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= StReset;
      rd_pend_q   <= 1'b0;
      owner_q     <= 1'b0;
      hold_full_q <= 1'b0;
      hold_q      <= '0;
    end else begin
      state_q     <= state_d;
      rd_pend_q   <= rd_pend_d;
      owner_q     <= owner_d;
      hold_full_q <= hold_full_d;
      hold_q      <= hold_d;
    end
  end

  assign cfg_ready_o    = cfg_ready;
  assign fetch_ready_o  = fetch_ready;
  assign cfg_data_v_o   = cfg_ret;
  assign cfg_data_o     = cfg_ret ? ram_data_i : '0;
  assign fetch_inst_v_o = hold_full_q;
  assign fetch_inst_o   = !hold_full_q ? '0 : (fetch_ret ? ram_data_i : hold_q);
  assign cce_run_o      = (state_q == StRun);

endmodule

// File: tb/tb_bp_cce_ucode_ram_arbiter.sv
// Scoreboard bench for bp_cce_ucode_ram_arbiter with a behavioural 1-cycle RAM.
module tb_bp_cce_ucode_ram_arbiter;
  localparam int unsigned PcW   = 8;
  localparam int unsigned InstW = 48;
`ifdef BP_CCE_UCODE_ARB_FAIR_EN
  localparam int unsigned FairGrantK = 9;
`else
  localparam int unsigned FairGrantK = 0;
`endif

  logic             clk, rst_n, mode;
  logic             cfg_v, cfg_w;
  logic [PcW-1:0]   cfg_addr;
  logic [InstW-1:0] cfg_data;
  logic             cfg_ready_o, cfg_data_v_o;
  logic [InstW-1:0] cfg_data_o;
  logic             fetch_v, fetch_yumi;
  logic [PcW-1:0]   fetch_pc;
  logic             fetch_ready_o, fetch_inst_v_o;
  logic [InstW-1:0] fetch_inst_o;
  logic             ram_v_o, ram_w_o;
  logic [PcW-1:0]   ram_addr_o;
  logic [InstW-1:0] ram_data_o, ram_rdata;
  logic             cce_run_o;

  bp_cce_ucode_ram_arbiter #(
    .cce_pc_width_p   (PcW),
    .cce_instr_width_p(InstW),
    .starve_limit_p   (8)
  ) dut (
    .clk_i         (clk),
    .reset_n_i     (rst_n),
    .mode_i        (mode),
    .cfg_v_i       (cfg_v),
    .cfg_w_i       (cfg_w),
    .cfg_addr_i    (cfg_addr),
    .cfg_data_i    (cfg_data),
    .cfg_ready_o   (cfg_ready_o),
    .cfg_data_v_o  (cfg_data_v_o),
    .cfg_data_o    (cfg_data_o),
    .fetch_v_i     (fetch_v),
    .fetch_pc_i    (fetch_pc),
    .fetch_ready_o (fetch_ready_o),
    .fetch_inst_v_o(fetch_inst_v_o),
    .fetch_inst_o  (fetch_inst_o),
    .fetch_yumi_i  (fetch_yumi),
    .ram_v_o       (ram_v_o),
    .ram_w_o       (ram_w_o),
    .ram_addr_o    (ram_addr_o),
    .ram_data_o    (ram_data_o),
    .ram_data_i    (ram_rdata),
    .cce_run_o     (cce_run_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [InstW-1:0] mem [0:255];
  int unsigned      ram_wr_cnt = 0;
  always @(posedge clk) begin
    if (ram_v_o) begin
      if (ram_w_o) begin
        mem[ram_addr_o] <= ram_data_o;
        ram_wr_cnt      <= ram_wr_cnt + 1;
      end else begin
        ram_rdata <= mem[ram_addr_o];
      end
    end
  end

  logic [InstW-1:0] dtab [4] = '{48'h1000_0000_0001, 48'h2000_0000_0002,
                                 48'h3000_0000_0003, 48'h0000_0000_ABCD};
  localparam logic [InstW-1:0] D5 = 48'hCAFE_F00D_5555;

  int unsigned      n_checks = 0;
  int unsigned      n_fail   = 0;
  logic [InstW-1:0] cfg_q [$];
  logic [InstW-1:0] fetch_q [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents returned data.
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (cfg_data_v_o) begin
        if (cfg_q.size() == 0) chk("cfg_data_unexpected", {15'd0, cfg_data_v_o, cfg_data_o}, 64'd0);
        else chk("cfg_data", {16'd0, cfg_data_o}, {16'd0, cfg_q.pop_front()});
      end
      if (fetch_inst_v_o && fetch_yumi) begin
        if (fetch_q.size() == 0) chk("fetch_inst_unexpected", {15'd0, fetch_inst_v_o, fetch_inst_o}, 64'd0);
        else chk("fetch_inst", {16'd0, fetch_inst_o}, {16'd0, fetch_q.pop_front()});
      end
    end
  end

  task automatic cfg_wr(input logic [PcW-1:0] a, input logic [InstW-1:0] d);
    cfg_v = 1'b1; cfg_w = 1'b1; cfg_addr = a; cfg_data = d;
    @(negedge clk);
    chk("cfg_wr_ready", {63'd0, cfg_ready_o}, 64'd1);
    chk("cfg_wr_fetch_ready", {63'd0, fetch_ready_o}, 64'd0);
    tick();
    cfg_v = 1'b0; cfg_w = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned pc_i;
    int unsigned grant_k;
    int unsigned wr_before;
    logic        got_fr, got_cr;

    rst_n = 1'b0; mode = 1'b0; cfg_v = 1'b0; cfg_w = 1'b0; cfg_addr = '0; cfg_data = '0;
    fetch_v = 1'b0; fetch_pc = '0; fetch_yumi = 1'b0;

    @(negedge clk);
    chk("reset_ctrl_outs", {57'd0, cfg_ready_o, cfg_data_v_o, fetch_ready_o, fetch_inst_v_o,
                            ram_v_o, ram_w_o, cce_run_o}, 64'd0);
    chk("reset_fetch_inst", {16'd0, fetch_inst_o}, 64'd0);
    chk("reset_cfg_data", {16'd0, cfg_data_o}, 64'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    tick();

    // CFG: load microcode and read addr 3 back
    for (int unsigned i = 0; i < 4; i++) cfg_wr(i[PcW-1:0], dtab[i]);
    cfg_wr(8'd5, D5);
    cfg_v = 1'b1; cfg_w = 1'b0; cfg_addr = 8'd3;
    cfg_q.push_back(48'h0000_0000_ABCD);
    @(negedge clk);
    chk("cfg_rd_ready", {63'd0, cfg_ready_o}, 64'd1);
    chk("cfg_rd_ram_v", {63'd0, ram_v_o}, 64'd1);
    tick();
    cfg_v = 1'b0;
    @(negedge clk);
    chk("cfg_rd_pulse", {63'd0, cfg_data_v_o}, 64'd1);
    chk("cfg_fetch_ready_low", {63'd0, fetch_ready_o}, 64'd0);
    tick();
    @(negedge clk);
    chk("cfg_rd_pulse_end", {63'd0, cfg_data_v_o}, 64'd0);
    chk("cfg_not_run", {63'd0, cce_run_o}, 64'd0);
    tick();

    // Enter RUN, stream pc 0..3 with yumi every cycle
    mode = 1'b1;
    tick();
    fetch_v = 1'b1; fetch_yumi = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      fetch_pc = i[PcW-1:0];
      fetch_q.push_back(dtab[i]);
      @(negedge clk);
      if (i == 0) chk("run_entered", {63'd0, cce_run_o}, 64'd1);
      chk("stream_fetch_ready", {63'd0, fetch_ready_o}, 64'd1);
      if (i > 0) chk("stream_inst_v", {63'd0, fetch_inst_v_o}, 64'd1);
      tick();
    end
    fetch_v = 1'b0;
    @(negedge clk);
    chk("stream_last_inst_v", {63'd0, fetch_inst_v_o}, 64'd1);
    tick();

    // Yumi held low: one request, then stall with data(0) held
    fetch_yumi = 1'b0; fetch_v = 1'b1; fetch_pc = 8'd0;
    fetch_q.push_back(dtab[0]);
    @(negedge clk);
    chk("hold_first_ready", {63'd0, fetch_ready_o}, 64'd1);
    tick();
    fetch_pc = 8'd1;
    @(negedge clk);
    chk("hold_ready_low", {63'd0, fetch_ready_o}, 64'd0);
    chk("hold_no_ram", {63'd0, ram_v_o}, 64'd0);
    chk("hold_inst_d0", {16'd0, fetch_inst_o}, {16'd0, dtab[0]});
    tick();
    @(negedge clk);
    chk("hold_no_ram2", {63'd0, ram_v_o}, 64'd0);
    chk("hold_keeps_d0", {15'd0, fetch_inst_v_o, fetch_inst_o}, {15'd0, 1'b1, dtab[0]});
    tick();
    fetch_v = 1'b0; fetch_yumi = 1'b1;
    tick();
    fetch_yumi = 1'b0;

    // RUN config write is refused; config read is serviced to cfg_data_o only
    wr_before = ram_wr_cnt;
    cfg_v = 1'b1; cfg_w = 1'b1; cfg_addr = 8'd7; cfg_data = 48'hDEAD_DEAD_DEAD;
    @(negedge clk);
    chk("run_cfg_wr_ready", {63'd0, cfg_ready_o}, 64'd0);
    chk("run_cfg_wr_ram_v", {63'd0, ram_v_o}, 64'd0);
    tick();
    cfg_w = 1'b0; cfg_addr = 8'd5;
    cfg_q.push_back(D5);
    @(negedge clk);
    chk("run_cfg_rd_ready", {63'd0, cfg_ready_o}, 64'd1);
    tick();
    cfg_v = 1'b0;
    @(negedge clk);
    chk("run_cfg_rd_not_fetch", {63'd0, fetch_inst_v_o}, 64'd0);
    chk("run_cfg_rd_v", {63'd0, cfg_data_v_o}, 64'd1);
    chk("run_no_ram_write", 64'(ram_wr_cnt), 64'(wr_before));
    tick();

    // Contention: fetch every cycle with a pending config read
    fetch_v = 1'b1; fetch_yumi = 1'b1; cfg_v = 1'b1; cfg_w = 1'b0; cfg_addr = 8'd5;
    pc_i = 0; grant_k = 0;
    for (int unsigned k = 1; k <= 12; k++) begin
      fetch_pc = pc_i[PcW-1:0];
      @(negedge clk);
      got_fr = fetch_ready_o;
      got_cr = cfg_v & cfg_ready_o;
      chk("contend_fetch_ready", {63'd0, fetch_ready_o}, (k == FairGrantK) ? 64'd0 : 64'd1);
      if (got_fr) fetch_q.push_back(dtab[pc_i]);
      if (got_cr) begin
        grant_k = k;
        cfg_q.push_back(D5);
      end
      tick();
      if (got_cr) cfg_v = 1'b0;
      if (got_fr) pc_i = (pc_i + 1) % 4;
    end
    chk("contend_cfg_grant_cycle", 64'(grant_k), 64'(FairGrantK));
    fetch_v = 1'b0; cfg_v = 1'b0;
    tick();
    fetch_yumi = 1'b0;
    tick();

    // Drop mode with a fetch in flight and the hold slot full
    fetch_v = 1'b1; fetch_pc = 8'd2;
    fetch_q.push_back(dtab[2]);
    tick();
    fetch_yumi = 1'b1; fetch_pc = 8'd3; mode = 1'b0;
    fetch_q.push_back(dtab[3]);
    @(negedge clk);
    chk("drain_setup_ready", {63'd0, fetch_ready_o}, 64'd1);
    tick();
    fetch_v = 1'b0; fetch_yumi = 1'b0;
    @(negedge clk);
    chk("drain_ctrl", {61'd0, cce_run_o, fetch_ready_o, cfg_ready_o}, 64'd0);
    tick();
    mode = 1'b1;
    @(negedge clk);
    chk("drain_waits", {62'd0, cce_run_o, cfg_ready_o}, 64'd0);
    chk("drain_hold_d3", {15'd0, fetch_inst_v_o, fetch_inst_o}, {15'd0, 1'b1, dtab[3]});
    tick();
    fetch_yumi = 1'b1;
    @(negedge clk);
    chk("drain_yumi_cycle", {63'd0, cfg_ready_o}, 64'd0);
    tick();
    fetch_yumi = 1'b0;
    @(negedge clk);
    chk("cfg_after_drain", {62'd0, cce_run_o, cfg_ready_o}, 64'd1);
    tick();
    @(negedge clk);
    chk("rerun_after_drain", {63'd0, cce_run_o}, 64'd1);
    tick();
    tick();

    chk("cfg_q_empty", 64'(cfg_q.size()), 64'd0);
    chk("fetch_q_empty", 64'(fetch_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
